// File: rtl/multdiv_sequencer_pkg.sv
// Shared constants, state encoding and payload types for the multdiv sequencer.
package multdiv_sequencer_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned ALUOP_W = 5;
  localparam int unsigned STATE_W = 2;

  localparam logic [ALUOP_W-1:0] ALUOP_MUL = 5'b00110;
  localparam logic [ALUOP_W-1:0] ALUOP_DIV = 5'b00111;

  localparam int unsigned RSTATUS_REG_DEFAULT = 30;

  localparam logic [DATA_W-1:0] EXC_CODE_MUL = 32'd4;
  localparam logic [DATA_W-1:0] EXC_CODE_DIV = 32'd5;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_START = 2'd1;
  localparam logic [STATE_W-1:0] ST_WAIT  = 2'd2;
  localparam logic [STATE_W-1:0] ST_WB    = 2'd3;

  // Operation captured at issue and held until the sequence ends
  typedef struct packed {
    logic              div;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
  } md_op_t;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_payload_t;

  function automatic logic [DATA_W-1:0] exc_code(input logic is_div);
    return is_div ? EXC_CODE_DIV : EXC_CODE_MUL;
  endfunction

endpackage

// File: rtl/multdiv_sequencer_timeout_counter.sv
// WAIT-state cycle counter; terminal_c flags the last permitted WAIT cycle.
module timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 48
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  // Saturates at LAST so a stalled enable cannot wrap back to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != LAST)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign terminal_c = enable & (count_q == LAST);

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences a multi-cycle mul/div: issue, start pulse, wait with timeout, writeback.
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 48,
  parameter int unsigned RSTATUS_REG    = RSTATUS_REG_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dx_valid,
  input  logic               dx_multdiv,
  input  logic [ALUOP_W-1:0] dx_aluop,
  input  logic [REG_W-1:0]   dx_rd,
  input  logic [DATA_W-1:0]  dx_opa,
  input  logic [DATA_W-1:0]  dx_opb,
  input  logic               flush,
  input  logic               md_ready,
  input  logic               md_exception,
  input  logic [DATA_W-1:0]  md_result,
  output logic               md_ctrl_mult,
  output logic               md_ctrl_div,
  output logic [DATA_W-1:0]  md_opa,
  output logic [DATA_W-1:0]  md_opb,
  output logic               stall,
  output logic               wb_valid,
  output logic [REG_W-1:0]   wb_rd,
  output logic [DATA_W-1:0]  wb_data,
  output logic               busy,
  output logic               timeout_err
);

  logic [STATE_W-1:0] state_q, state_next;
  md_op_t             op_q, op_next;
  wb_payload_t        wb_q, wb_next;
  logic               mult_q, mult_next;
  logic               div_q, div_next;
  logic               busy_q;
  logic               terr_q, terr_next;

  logic issue_c;
  logic op_div_c;
  logic tmo_terminal_c;
  logic unused_aluop;

  // Only bit 0 of the ALUOp distinguishes mul from div once the decoder flags multdiv
  assign op_div_c     = (dx_aluop[0] == ALUOP_DIV[0]);
  assign unused_aluop = ^dx_aluop[ALUOP_W-1:1];

  // Gated by rst_n so stall stays low while reset is held
  assign issue_c = rst_n & (state_q == ST_IDLE) & dx_valid & dx_multdiv & ~flush;

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state_q != ST_WAIT),
    .enable    (state_q == ST_WAIT),
    .terminal_c(tmo_terminal_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      wb_q    <= '0;
      mult_q  <= 1'b0;
      div_q   <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_next;
      op_q    <= op_next;
      wb_q    <= wb_next;
      mult_q  <= mult_next;
      div_q   <= div_next;
      busy_q  <= (state_next != ST_IDLE);
      terr_q  <= terr_next;
    end
  end

  // Next-state plus next values of every registered output
  always_comb begin
    state_next = state_q;
    op_next    = op_q;
    wb_next    = '0;
    mult_next  = 1'b0;
    div_next   = 1'b0;
    terr_next  = terr_q;

    case (state_q)
      ST_IDLE: begin
        if (issue_c) begin
          state_next = ST_START;
          op_next    = '{div: op_div_c, rd: dx_rd, opa: dx_opa, opb: dx_opb};
          mult_next  = ~op_div_c;
          div_next   = op_div_c;
        end
      end
      ST_START: begin
        state_next = flush ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        // flush beats md_ready, which beats the timeout
        if (flush) begin
          state_next = ST_IDLE;
        end else if (md_ready) begin
          state_next = ST_WB;
          if (md_exception) begin
            wb_next = '{valid: 1'b1, rd: REG_W'(RSTATUS_REG), data: exc_code(op_q.div)};
          end else begin
            wb_next = '{valid: (op_q.rd != '0), rd: op_q.rd, data: md_result};
          end
        end else if (tmo_terminal_c) begin
          state_next = ST_WB;
          wb_next    = '{valid: 1'b1, rd: REG_W'(RSTATUS_REG), data: exc_code(op_q.div)};
          terr_next  = 1'b1;
        end
      end
      ST_WB: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign stall        = issue_c | (state_q == ST_START) | (state_q == ST_WAIT);
  assign md_ctrl_mult = mult_q;
  assign md_ctrl_div  = div_q;
  assign md_opa       = op_q.opa;
  assign md_opb       = op_q.opb;
  assign wb_valid     = wb_q.valid;
  assign wb_rd        = wb_q.rd;
  assign wb_data      = wb_q.data;
  assign busy         = busy_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Randomized self-checking bench for multdiv_sequencer against a cycle-timeline model.
module tb_multdiv_sequencer;
  import multdiv_sequencer_pkg::*;

  localparam int T = 48;

  logic        clk, rst_n;
  logic        dx_valid, dx_multdiv, flush, md_ready, md_exception;
  logic [4:0]  dx_aluop, dx_rd;
  logic [31:0] dx_opa, dx_opb, md_result;
  logic        md_ctrl_mult, md_ctrl_div, stall, wb_valid, busy, timeout_err;
  logic [31:0] md_opa, md_opb, wb_data;
  logic [4:0]  wb_rd;

  int vectors = 0;
  int errors  = 0;
  bit exp_terr = 0;

  multdiv_sequencer #(.TIMEOUT_CYCLES(T), .RSTATUS_REG(30)) dut (
    .clk(clk), .rst_n(rst_n),
    .dx_valid(dx_valid), .dx_multdiv(dx_multdiv), .dx_aluop(dx_aluop), .dx_rd(dx_rd),
    .dx_opa(dx_opa), .dx_opb(dx_opb), .flush(flush),
    .md_ready(md_ready), .md_exception(md_exception), .md_result(md_result),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_opa(md_opa), .md_opb(md_opb), .stall(stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got hang want completion");
    $fatal(1);
  end

  // One operation: expected timeline comes from when ready/flush/timeout occur relative to issue.
  // Cycle 0 = issue, 1 = start pulse, 2.. = WAIT cycles.
  task automatic do_op(input string tag, input bit div, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b,
                       input int ready_cyc, input bit exc, input int flush_cyc,
                       output int n_stall, output int n_pulse, output int n_wb);
    int wb_cyc, last_busy, last_stall, lim;
    bit exc_wb, tmo;
    logic [31:0] res, exp_data;
    logic [4:0]  exp_rd;
    logic exp_stall, exp_busy, exp_mult, exp_div, exp_wbv;
    n_stall = 0; n_pulse = 0; n_wb = 0;
    exc_wb = 0; tmo = 0; wb_cyc = -1;
    lim = (ready_cyc != 0 && ready_cyc <= 1 + T) ? ready_cyc : 1 + T;
    if (flush_cyc != 0 && flush_cyc <= lim) begin
      last_busy = flush_cyc; last_stall = flush_cyc;
    end else begin
      if (ready_cyc != 0 && ready_cyc <= 1 + T) begin
        wb_cyc = ready_cyc + 1; exc_wb = exc;
      end else begin
        wb_cyc = 2 + T; exc_wb = 1; tmo = 1;
      end
      last_busy = wb_cyc; last_stall = wb_cyc - 1;
    end
    if (div) res = (b == 0) ? 32'hDEAD_BEEF : a / b;
    else     res = a * b;
    exp_data = exc_wb ? (div ? 32'd5 : 32'd4) : res;
    exp_rd   = exc_wb ? 5'd30 : rd;

    for (int c = 0; c <= last_busy + 1; c++) begin
      if (c == 0) begin
        dx_valid = 1; dx_multdiv = 1; dx_aluop = div ? ALUOP_DIV : ALUOP_MUL;
        dx_rd = rd; dx_opa = a; dx_opb = b;
      end else begin
        dx_valid   = (c <= last_busy) ? 1'($urandom_range(0, 1)) : 1'b0;
        dx_multdiv = (c <= last_busy) ? 1'($urandom_range(0, 1)) : 1'b0;
        dx_aluop = 5'($urandom); dx_rd = 5'($urandom);
        dx_opa = $urandom; dx_opb = $urandom;
      end
      flush        = (flush_cyc != 0 && c == flush_cyc);
      md_ready     = (ready_cyc != 0 && c == ready_cyc);
      md_exception = md_ready ? exc : 1'($urandom_range(0, 1));
      md_result    = md_ready ? res : $urandom;
      if (c == wb_cyc && tmo) exp_terr = 1;

      exp_stall = (c <= last_stall);
      exp_busy  = (c >= 1 && c <= last_busy);
      exp_mult  = (c == 1 && !div);
      exp_div   = (c == 1 && div);
      exp_wbv   = (c == wb_cyc) && (exc_wb || rd != 0);

      @(negedge clk);
      n_stall += int'(stall);
      n_pulse += int'(md_ctrl_mult) + int'(md_ctrl_div);
      n_wb    += int'(wb_valid);
      vectors++;
      if (stall !== exp_stall) begin errors++;
        $display("FAIL %s stall c=%0d got %b want %b", tag, c, stall, exp_stall); end
      vectors++;
      if (busy !== exp_busy) begin errors++;
        $display("FAIL %s busy c=%0d got %b want %b", tag, c, busy, exp_busy); end
      vectors++;
      if (md_ctrl_mult !== exp_mult) begin errors++;
        $display("FAIL %s md_ctrl_mult c=%0d got %b want %b", tag, c, md_ctrl_mult, exp_mult); end
      vectors++;
      if (md_ctrl_div !== exp_div) begin errors++;
        $display("FAIL %s md_ctrl_div c=%0d got %b want %b", tag, c, md_ctrl_div, exp_div); end
      vectors++;
      if (wb_valid !== exp_wbv) begin errors++;
        $display("FAIL %s wb_valid c=%0d got %b want %b", tag, c, wb_valid, exp_wbv); end
      vectors++;
      if (timeout_err !== exp_terr) begin errors++;
        $display("FAIL %s timeout_err c=%0d got %b want %b", tag, c, timeout_err, exp_terr); end
      if (exp_busy) begin
        vectors++;
        if (md_opa !== a || md_opb !== b) begin errors++;
          $display("FAIL %s md_opa/opb c=%0d got %h/%h want %h/%h", tag, c, md_opa, md_opb, a, b); end
      end
      if (exp_wbv) begin
        vectors++;
        if (wb_rd !== exp_rd || wb_data !== exp_data) begin errors++;
          $display("FAIL %s wb_rd/data c=%0d got %0d/%h want %0d/%h", tag, c, wb_rd, wb_data, exp_rd, exp_data); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 0; dx_valid = 1; dx_multdiv = 1; dx_aluop = ALUOP_MUL; dx_rd = 5'd7;
    dx_opa = 32'h1234; dx_opb = 32'h5678; flush = 0; md_ready = 1; md_exception = 1;
    md_result = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({stall, busy, md_ctrl_mult, md_ctrl_div, wb_valid, timeout_err} !== 6'b0 ||
        md_opa !== 0 || md_opb !== 0 || wb_rd !== 0 || wb_data !== 0) begin
      errors++;
      $display("FAIL reset_outputs got stall=%b busy=%b wbv=%b terr=%b opa=%h want all zero",
               stall, busy, wb_valid, timeout_err, md_opa);
    end
    @(posedge clk); #1;
    rst_n = 1; dx_valid = 0; md_ready = 0; md_exception = 0;
    exp_terr = 0;
  endtask

  task automatic test_mul_basic;
    int ns, np, nw;
    do_op("mul_basic", 0, 5'd3, 32'd7, 32'd6, 18, 0, 0, ns, np, nw);
    vectors++;
    if (ns != 19) begin errors++; $display("FAIL mul_basic stall_cycles got %0d want 19", ns); end
    vectors++;
    if (np != 1 || nw != 1) begin errors++;
      $display("FAIL mul_basic pulses/wbs got %0d/%0d want 1/1", np, nw); end
  endtask

  task automatic test_div_exception;
    int ns, np, nw;
    do_op("div_exc", 1, 5'd12, 32'd100, 32'd0, 9, 1, 0, ns, np, nw);
    vectors++;
    if (nw != 1) begin errors++; $display("FAIL div_exc wb_count got %0d want 1", nw); end
  endtask

  task automatic test_ready_at_timeout;
    int ns, np, nw;
    do_op("ready_at_tmo", 1, 5'd8, 32'd1000, 32'd7, 1 + T, 0, 0, ns, np, nw);
  endtask

  task automatic test_flush;
    int ns, np, nw;
    do_op("flush_wait5", 0, 5'd4, 32'd3, 32'd9, 20, 0, 6, ns, np, nw);
    vectors++;
    if (nw != 0) begin errors++; $display("FAIL flush_wait5 wb_count got %0d want 0", nw); end
    do_op("flush_start", 1, 5'd4, 32'd30, 32'd9, 10, 0, 1, ns, np, nw);
    vectors++;
    if (np != 1 || nw != 0) begin errors++;
      $display("FAIL flush_start pulses/wbs got %0d/%0d want 1/0", np, nw); end
  endtask

  // Issue inputs held high throughout: second op may only start the cycle after WB
  task automatic test_back_to_back;
    localparam int D = 3;
    int pulse_c[$];
    int wb_c[$];
    logic [31:0] wb_d[$];
    logic [31:0] a1, b1, a2, b2;
    a1 = $urandom_range(1, 60000); b1 = $urandom_range(1, 60000);
    a2 = $urandom_range(1, 60000); b2 = $urandom_range(1, 60000);
    for (int c = 0; c <= 6 + 2 * D; c++) begin
      dx_valid = (c <= 3 + D); dx_multdiv = 1; dx_aluop = ALUOP_MUL; dx_rd = 5'd5;
      dx_opa = (c < 2 + D) ? a1 : a2; dx_opb = (c < 2 + D) ? b1 : b2;
      flush = 0; md_exception = 0;
      md_ready  = (c == 1 + D) || (c == 4 + 2 * D);
      md_result = (c == 1 + D) ? a1 * b1 : (c == 4 + 2 * D) ? a2 * b2 : $urandom;
      @(negedge clk);
      if (md_ctrl_mult || md_ctrl_div) pulse_c.push_back(c);
      if (wb_valid) begin wb_c.push_back(c); wb_d.push_back(wb_data); end
      if (c == 2 + D) begin
        vectors++;
        if (stall !== 1'b0) begin errors++; $display("FAIL b2b stall_in_wb got %b want 0", stall); end
      end
      @(posedge clk); #1;
    end
    dx_valid = 0;
    vectors++;
    if (pulse_c.size() != 2) begin errors++;
      $display("FAIL b2b pulse_count got %0d want 2", pulse_c.size());
    end else begin
      vectors++;
      if (pulse_c[0] != 1 || pulse_c[1] != 4 + D) begin errors++;
        $display("FAIL b2b pulse_cycles got %0d,%0d want 1,%0d", pulse_c[0], pulse_c[1], 4 + D); end
    end
    vectors++;
    if (wb_c.size() != 2) begin errors++;
      $display("FAIL b2b wb_count got %0d want 2", wb_c.size());
    end else begin
      vectors++;
      if (wb_c[0] != 2 + D || wb_c[1] != 5 + 2 * D || wb_d[0] !== a1 * b1 || wb_d[1] !== a2 * b2) begin
        errors++;
        $display("FAIL b2b wb got c%0d=%h c%0d=%h want c%0d=%h c%0d=%h", wb_c[0], wb_d[0], wb_c[1], wb_d[1],
                 2 + D, a1 * b1, 5 + 2 * D, a2 * b2);
      end
    end
  endtask

  task automatic test_random;
    int ns, np, nw, rdy, fl, lim, sel;
    bit div, exc;
    logic [4:0]  rd;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      div = 1'($urandom_range(0, 1));
      rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      a   = $urandom;
      b   = div ? (($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 1000))) : $urandom;
      exc = (div && b == 0) || ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 9);
      rdy = (sel == 0) ? 0 : (sel == 1) ? 1 + T : $urandom_range(2, 20);
      lim = (rdy != 0) ? rdy : 1 + T;
      fl  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, lim) : 0;
      do_op("random", div, rd, a, b, rdy, exc, fl, ns, np, nw);
    end
  endtask

  task automatic test_timeout;
    int ns, np, nw;
    do_op("timeout", 1, 5'd6, 32'd77, 32'd11, 0, 0, 0, ns, np, nw);
    vectors++;
    if (nw != 1) begin errors++; $display("FAIL timeout wb_count got %0d want 1", nw); end
    do_op("after_timeout", 0, 5'd2, 32'd5, 32'd5, 4, 0, 0, ns, np, nw);
  endtask

  task automatic test_reset_mid;
    int ns, np, nw;
    dx_valid = 1; dx_multdiv = 1; dx_aluop = ALUOP_MUL; dx_rd = 5'd9;
    dx_opa = 32'hAAAA_5555; dx_opb = 32'h0F0F_F0F0; flush = 0; md_ready = 0; md_exception = 0;
    repeat (6) begin @(posedge clk); #1; end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || stall !== 1'b1 || timeout_err !== exp_terr) begin errors++;
      $display("FAIL reset_mid pre busy/stall/terr got %b/%b/%b want 1/1/%b", busy, stall, timeout_err, exp_terr); end
    #2; rst_n = 0; #1;
    vectors++;
    if ({stall, busy, md_ctrl_mult, md_ctrl_div, wb_valid, timeout_err} !== 6'b0 ||
        md_opa !== 0 || md_opb !== 0 || wb_rd !== 0 || wb_data !== 0) begin
      errors++;
      $display("FAIL reset_mid outputs got stall=%b busy=%b terr=%b opa=%h opb=%h want all zero",
               stall, busy, timeout_err, md_opa, md_opb);
    end
    exp_terr = 0;
    @(posedge clk); #1;
    rst_n = 1; dx_valid = 0;
    do_op("mul_rd0", 0, 5'd0, 32'd12, 32'd13, 6, 0, 0, ns, np, nw);
    vectors++;
    if (nw != 0 || np != 1) begin errors++;
      $display("FAIL mul_rd0 wbs/pulses got %0d/%0d want 0/1", nw, np); end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_div_exception();
    test_ready_at_timeout();
    test_flush();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_sequencer.md
MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 48, max WAIT cycles before forced abort.
REQ-002 Parameter RSTATUS_REG, 30, register index for exception writeback.
REQ-003 clock  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 dx_valid  in  1  X-stage instruction valid (not a nop).
REQ-006 dx_multdiv  in  1  X-stage instruction is mul/div (decoder multdiv flag).
REQ-007 dx_aluop  in  5  ALUOp of the X-stage instruction; 00110 = mul, 00111 = div.
REQ-008 dx_rd  in  5  destination register of the X-stage instruction.
REQ-009 dx_opa, dx_opb  in  32 each  bypassed operands from the X stage.
REQ-010 flush  in  1  kill in-flight multdiv (taken branch/jump or bex).
REQ-011 md_ready, md_exception  in  1 each  multdiv unit result ready / overflow or divide-by-zero.
REQ-012 md_result  in  32  multdiv unit result.
REQ-013 md_ctrl_mult, md_ctrl_div  out  1 each  one-cycle start pulses to the multdiv unit.
REQ-014 md_opa, md_opb  out  32 each  latched operands, held stable from START until IDLE.
REQ-015 stall  out  1  freeze PC, F/D and D/X latches.
REQ-016 wb_valid  out  1  one-cycle writeback strobe; wb_rd  out  5; wb_data  out  32.
REQ-017 busy  out  1  state != IDLE; timeout_err  out  1  sticky abort flag.

Function
REQ-018 States SHALL be IDLE, START, WAIT and WB.
REQ-019 Issue SHALL be dx_valid & dx_multdiv & ~flush while in IDLE; issue in any other state SHALL be ignored.
REQ-020 On issue, the block SHALL latch dx_opa, dx_opb, dx_rd and op type (dx_aluop[0]: 0 = mul, 1 = div) and go to START.
REQ-021 stall SHALL be combinationally high in the issue cycle and in START and WAIT, and low in IDLE (no issue) and WB.
REQ-022 START SHALL last exactly one cycle, asserting exactly one of md_ctrl_mult/md_ctrl_div, then go to WAIT.
REQ-023 WAIT SHALL increment a cycle counter cleared on entry; md_ready SHALL move the block to WB next cycle.
REQ-024 If the counter reaches TIMEOUT_CYCLES without md_ready, the block SHALL go to WB as an exception and set timeout_err.
REQ-025 md_ready in the same cycle as the timeout SHALL take priority; timeout_err stays clear.
REQ-026 WB SHALL last one cycle with wb_valid=1, then return to IDLE, with no issue recognised during WB.
REQ-027 Normal WB SHALL drive wb_rd = latched rd and wb_data = md_result captured when md_ready rose.
REQ-028 Exception WB (md_exception or timeout) SHALL drive wb_rd = RSTATUS_REG and wb_data = 4 (mul) or 5 (div).
REQ-029 Normal WB with latched rd = 0 SHALL suppress wb_valid.
REQ-030 flush in START or WAIT SHALL return the block to IDLE next cycle with no writeback and no further start pulse.
REQ-031 Latency SHALL be: issue at t, pulse at t+1, md_ready at cycle w gives WB at w+1, IDLE at w+2.
REQ-032 timeout_err SHALL clear only on reset.

Reset
REQ-033 Asserting reset SHALL immediately force IDLE, clear the counter and timeout_err, and drive every output to 0, including mid-operation.
REQ-034 After reset deasserts, the first issue SHALL be accepted on the next rising edge.

Structure
REQ-035 The shared package SHALL hold the ALUOp constants (MUL = 00110, DIV = 00111), the RSTATUS index default, exception codes 4 and 5, and the state encoding.
REQ-036 The wait counter SHALL be a sub-module named timeout_counter, with enable, clear, terminal-count output and a width sized from TIMEOUT_CYCLES.

Verification
REQ-037 mul with rd=3, operands 7 and 6, md_ready 17 cycles after the pulse -> one md_ctrl_mult pulse; stall high for 19 cycles; wb_rd=3, wb_data=42.
REQ-038 div with md_exception at ready -> wb_rd=30, wb_data=5, timeout_err=0.
REQ-039 div with no md_ready for 48 WAIT cycles -> WB with wb_rd=30, wb_data=5; timeout_err=1 until reset.
REQ-040 Back-to-back mul, mul -> second issue accepted only in the cycle after WB; exactly two pulses; two writebacks.
REQ-041 flush in WAIT cycle 5 -> IDLE next cycle, no wb_valid, stall low.
REQ-042 reset asserted during WAIT -> all outputs 0 immediately; a later mul with rd=0 and no exception -> no wb_valid.
